sar_multichannel_controller: RTL and testbench
==============================================

Name: sar_multichannel_controller

Overview:
Next-generation SAR ADC digital controller. It merges sample/hold timing generation and successive-approximation logic into one FSM, and adds multi-channel round-robin sequencing, a start/valid handshake, single or continuous conversion modes, and configurable per-bit settle time. It sits between the analog front end (input mux, S/H switch, capacitive DAC, comparator) and the user-side digital fabric.

Parameters:
PRECISION, 10, result width in bits (>=2)
NUM_CHANNELS, 4, analog input channels sequenced round-robin (>=1)
SAMPLE_CYCLES, 2, clk cycles sample is held high per conversion (>=1)
BIT_CYCLES, 1, clk cycles per bit trial; cmp is sampled on the last cycle of each trial (>=1)
OSR_LOG2, 2, log2 of the oversampling ratio; used only with SAR_OVERSAMPLE_EN

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; honoured only in IDLE
cont  input  1  continuous mode; sampled when each conversion completes
cmp  input  1  comparator output; 1 = Vin >= Vdac(dac_code)
sample  output  1  S/H switch control; high during SAMPLE
ch_sel  output  CH_W  analog mux select, where CH_W = max(1, clog2(NUM_CHANNELS))
dac_code  output  PRECISION  current trial code to the DAC
busy  output  1  high in any state other than IDLE
data_out  output  PRECISION  last result; held until the next result
data_ch  output  CH_W  channel that produced data_out
data_valid  output  1  one-cycle strobe when data_out/data_ch update

Behaviour:
- Reset: on the rising edge with rst=1, the block enters IDLE. All outputs are 0: sample, ch_sel, dac_code, busy, data_out, data_ch, data_valid. The channel pointer is 0. Reset applies from any state and aborts a conversion in progress; no data_valid is produced for the aborted conversion.
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE:
  - start=1 -> SAMPLE on the next edge.
  - start in any other state is ignored and is not queued.
- SAMPLE:
  - sample=1 and ch_sel = channel pointer for exactly SAMPLE_CYCLES cycles, then CONVERT.
  - dac_code = 0.
- CONVERT:
  - There are PRECISION trials, MSB first, each BIT_CYCLES long.
  - Trial k drives dac_code with the already-decided upper bits, bit k set to 1, and all lower bits 0.
  - On the last cycle of a trial, bit k is kept when cmp=1 and cleared when cmp=0.
  - ch_sel stays stable for the whole conversion.
- DONE (1 cycle):
  - data_out = final code, data_ch = channel, data_valid=1.
  - The channel pointer advances, wrapping from NUM_CHANNELS-1 to 0. With NUM_CHANNELS=1 it stays 0.
  - Next state is SAMPLE if cont=1 and IDLE if cont=0.
- Latency: with start accepted at cycle 0, data_valid is high in cycle SAMPLE_CYCLES + PRECISION*BIT_CYCLES + 1.
- Continuous-mode throughput: one result every SAMPLE_CYCLES + PRECISION*BIT_CYCLES + 1 cycles.
- Boundaries:
  - cmp all-ones gives 2^PRECISION-1; cmp all-zeros gives 0.
  - cmp is ignored outside the decision cycles.
  - Deasserting cont mid-conversion finishes the current conversion, then the block goes IDLE.
  - start=1 in the same cycle as DONE is ignored.

Optional Feature:
Macro SAR_OVERSAMPLE_EN.
- Defined:
  - Each channel slot performs 2^OSR_LOG2 back-to-back conversions. The SAMPLE and CONVERT sequence repeats without a DONE in between, and ch_sel is unchanged.
  - Results are summed in a PRECISION+OSR_LOG2-bit accumulator.
  - data_out = accumulator >> OSR_LOG2 (truncating average). data_valid and the channel advance occur once per slot.
  - Reset clears the accumulator and the oversample counter.
  - cont is sampled only at the end of a slot.
- Undefined: the accumulator and counter are absent, and behaviour is exactly as above.

Decomposition:
- Package sar_ctrl_pkg holds:
  - the state enum (IDLE, SAMPLE, CONVERT, DONE);
  - a function computing CH_W;
  - localparam helpers for the counter widths (clog2 of SAMPLE_CYCLES, BIT_CYCLES, PRECISION).
- One sub-module, sar_trial_engine, holds the successive-approximation register, the bit index, and the BIT_CYCLES timer.
  - Inputs: clk, rst, go, cmp.
  - Outputs: dac_code, result, done.
- The top level holds the FSM, the sample timer, channel sequencing, output registers, and the oversampling logic.

Test Plan:
All scenarios use PRECISION=4, NUM_CHANNELS=3, SAMPLE_CYCLES=2, BIT_CYCLES=1 unless stated.
1. Comparator model with Vin code 0xA; start at cycle 0, cont=0 -> sample high in cycles 1-2; dac_code sequence 8, C, A, B; data_out=0xA, data_ch=0; data_valid only in cycle 7; then IDLE with busy=0.
2. cont=1 held; per-channel Vin codes 3, F, 0 -> valids every 7 cycles with (data_ch, data_out) = (0,3), (1,F), (2,0), (0,3), ...; wrap from 2 to 0.
3. BIT_CYCLES=3; Vin code 5 -> cmp honoured only on the 3rd cycle of each trial, with cmp toggling on the other cycles; data_out=5; data_valid in cycle 15.
4. Reset asserted in the 2nd CONVERT cycle -> next edge all outputs 0, no data_valid, channel pointer 0; a following start converts channel 0.
5. start pulsed during SAMPLE and during DONE -> ignored; exactly one data_valid per accepted start.
6. SAR_OVERSAMPLE_EN, OSR_LOG2=2, Vin codes 4, 5, 5, 6 across the four conversions -> a single data_valid with data_out=5, data_ch=0, after 4*(2+4) cycles of sample/convert activity.

Source files
------------

// File: rtl/sar_ctrl_pkg.sv
// Shared types and width helpers for the multi-channel SAR controller.
package sar_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_t;

    // Mux-select width; a single channel still needs a 1-bit port.
    function automatic int ch_width(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_trial_engine.sv
// Successive-approximation register: PRECISION MSB-first trials of BIT_CYCLES each,
// cmp decided on the last cycle of every trial.
module sar_trial_engine
    import sar_ctrl_pkg::*;
#(
    parameter int PRECISION  = 10,
    parameter int BIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 cmp,
    output logic [PRECISION-1:0] dac_code,
    output logic [PRECISION-1:0] result,
    output logic                 done
);

    localparam int IW = cnt_width(PRECISION);
    localparam int TW = cnt_width(BIT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] I_TOP  = IW'(PRECISION - 1);

    logic [PRECISION-1:0] sar_reg;
    logic [IW-1:0]        idx_reg;
    logic [TW-1:0]        timer_reg;
    logic                 active_reg;
    logic [PRECISION-1:0] decided;
    logic                 decide;

    // Current code with the bit under trial replaced by the comparator verdict.
    generate
        for (genvar gi = 0; gi < PRECISION; gi++) begin : g_decide
            assign decided[gi] = (IW'(gi) == idx_reg) ? cmp : sar_reg[gi];
        end
    endgenerate

    assign decide   = active_reg && (timer_reg == T_LAST);
    assign done     = decide && (idx_reg == '0);
    assign result   = decided;
    assign dac_code = sar_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sar_reg    <= '0;
            idx_reg    <= '0;
            timer_reg  <= '0;
            active_reg <= 1'b0;
        end else if (go) begin
            sar_reg    <= {1'b1, {(PRECISION-1){1'b0}}};
            idx_reg    <= I_TOP;
            timer_reg  <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (decide) begin
                timer_reg <= '0;
                if (idx_reg == '0) begin
                    // Park the DAC at zero once the last bit is resolved.
                    active_reg <= 1'b0;
                    sar_reg    <= '0;
                end else begin
                    sar_reg <= decided | (PRECISION'(1) << (idx_reg - IW'(1)));
                    idx_reg <= idx_reg - IW'(1);
                end
            end else begin
                timer_reg <= timer_reg + TW'(1);
            end
        end
    end

endmodule

// File: rtl/sar_multichannel_controller.sv
// SAR ADC controller: sample/hold timing, SAR sequencing, round-robin channels.
// Optional build macro SAR_OVERSAMPLE_EN averages 2^OSR_LOG2 conversions per channel slot.
module sar_multichannel_controller
    import sar_ctrl_pkg::*;
#(
    parameter int PRECISION     = 10,
    parameter int NUM_CHANNELS  = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int BIT_CYCLES    = 1,
    parameter int OSR_LOG2      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                cont,
    input  logic                                cmp,
    output logic                                sample,
    output logic [ch_width(NUM_CHANNELS)-1:0]   ch_sel,
    output logic [PRECISION-1:0]                dac_code,
    output logic                                busy,
    output logic [PRECISION-1:0]                data_out,
    output logic [ch_width(NUM_CHANNELS)-1:0]   data_ch,
    output logic                                data_valid
);

    localparam int CH_W = ch_width(NUM_CHANNELS);
    localparam int SW   = cnt_width(SAMPLE_CYCLES);
    localparam logic [SW-1:0]   S_LAST  = SW'(SAMPLE_CYCLES - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);

    sar_state_t           state_reg;
    logic [SW-1:0]        sample_cnt_reg;
    logic [CH_W-1:0]      ch_ptr_reg;
    logic [CH_W-1:0]      ch_next;
    logic                 go;
    logic                 trial_done;
    logic [PRECISION-1:0] trial_code;

    // The engine loads its first trial on the final sample cycle so CONVERT starts at the MSB.
    assign go      = (state_reg == ST_SAMPLE) && (sample_cnt_reg == S_LAST);
    assign ch_next = (ch_ptr_reg == CH_LAST) ? '0 : ch_ptr_reg + CH_W'(1);

`ifdef SAR_OVERSAMPLE_EN
    localparam int AW = PRECISION + OSR_LOG2;
    localparam int OW = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
    localparam logic [OW-1:0] OSR_LAST = OW'((1 << OSR_LOG2) - 1);

    logic [AW-1:0] acc_reg;
    logic [AW-1:0] acc_sum;
    logic [OW-1:0] osr_cnt_reg;

    assign acc_sum = acc_reg + AW'(trial_code);
`endif

    sar_trial_engine #(
        .PRECISION  (PRECISION),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_engine (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .cmp      (cmp),
        .dac_code (dac_code),
        .result   (trial_code),
        .done     (trial_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            sample_cnt_reg <= '0;
            ch_ptr_reg     <= '0;
            sample         <= 1'b0;
            ch_sel         <= '0;
            busy           <= 1'b0;
            data_out       <= '0;
            data_ch        <= '0;
            data_valid     <= 1'b0;
`ifdef SAR_OVERSAMPLE_EN
            acc_reg        <= '0;
            osr_cnt_reg    <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_SAMPLE;
                        sample         <= 1'b1;
                        busy           <= 1'b1;
                        ch_sel         <= ch_ptr_reg;
                        sample_cnt_reg <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (sample_cnt_reg == S_LAST) begin
                        state_reg <= ST_CONVERT;
                        sample    <= 1'b0;
                    end else begin
                        sample_cnt_reg <= sample_cnt_reg + SW'(1);
                    end
                end
                ST_CONVERT: begin
                    if (trial_done) begin
`ifdef SAR_OVERSAMPLE_EN
                        if (osr_cnt_reg == OSR_LAST) begin
                            state_reg   <= ST_DONE;
                            data_out    <= acc_sum[AW-1:OSR_LOG2];
                            data_ch     <= ch_sel;
                            data_valid  <= 1'b1;
                            ch_ptr_reg  <= ch_next;
                            acc_reg     <= '0;
                            osr_cnt_reg <= '0;
                        end else begin
                            // Resample the same channel without passing through DONE.
                            state_reg      <= ST_SAMPLE;
                            sample         <= 1'b1;
                            sample_cnt_reg <= '0;
                            acc_reg        <= acc_sum;
                            osr_cnt_reg    <= osr_cnt_reg + OW'(1);
                        end
`else
                        state_reg  <= ST_DONE;
                        data_out   <= trial_code;
                        data_ch    <= ch_sel;
                        data_valid <= 1'b1;
                        ch_ptr_reg <= ch_next;
`endif
                    end
                end
                ST_DONE: begin
                    if (cont) begin
                        state_reg      <= ST_SAMPLE;
                        sample         <= 1'b1;
                        ch_sel         <= ch_ptr_reg;
                        sample_cnt_reg <= '0;
                    end else begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_multichannel_controller.sv
// Directed + randomized checks of two controller instances (BIT_CYCLES 1 and 3) against an ideal-comparator model.
module tb_sar_multichannel_controller;

    localparam int P = 4;
    localparam int N = 3;
    localparam int S = 2;
    localparam int OSR_LOG2 = 2;
`ifdef SAR_OVERSAMPLE_EN
    localparam int OSR_N = 1 << OSR_LOG2;
`else
    localparam int OSR_N = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_i   [2];
    logic       start_i [2];
    logic       cont_i  [2];
    logic       cmp_i   [2];
    logic       sample_o[2];
    logic [1:0] ch_sel_o[2];
    logic [3:0] dac_o   [2];
    logic       busy_o  [2];
    logic [3:0] dout_o  [2];
    logic [1:0] dch_o   [2];
    logic       dv_o    [2];

    logic [3:0] vin [N];
    int exp_ptr [2];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            sar_multichannel_controller #(
                .PRECISION     (P),
                .NUM_CHANNELS  (N),
                .SAMPLE_CYCLES (S),
                .BIT_CYCLES    ((gi == 0) ? 1 : 3),
                .OSR_LOG2      (OSR_LOG2)
            ) dut (
                .clk        (clk),
                .rst        (rst_i[gi]),
                .start      (start_i[gi]),
                .cont       (cont_i[gi]),
                .cmp        (cmp_i[gi]),
                .sample     (sample_o[gi]),
                .ch_sel     (ch_sel_o[gi]),
                .dac_code   (dac_o[gi]),
                .busy       (busy_o[gi]),
                .data_out   (dout_o[gi]),
                .data_ch    (dch_o[gi]),
                .data_valid (dv_o[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk($sformatf("u%0d %s sample", i, tag), sample_o[i], 0);
        chk($sformatf("u%0d %s ch_sel", i, tag), ch_sel_o[i], 0);
        chk($sformatf("u%0d %s dac_code", i, tag), dac_o[i], 0);
        chk($sformatf("u%0d %s busy", i, tag), busy_o[i], 0);
        chk($sformatf("u%0d %s data_out", i, tag), dout_o[i], 0);
        chk($sformatf("u%0d %s data_ch", i, tag), dch_o[i], 0);
        chk($sformatf("u%0d %s data_valid", i, tag), dv_o[i], 0);
    endtask

    task automatic reset_inst(input int i);
        @(negedge clk);
        rst_i[i] = 1'b1;
        start_i[i] = 1'b0;
        cont_i[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero(i, "reset");
        rst_i[i] = 1'b0;
        exp_ptr[i] = 0;
    endtask

    task automatic start_conv(input int i);
        @(negedge clk);
        start_i[i] = 1'b1;
        cmp_i[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_check(input int i, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            start_i[i] = 1'b0;
            chk($sformatf("u%0d idle busy", i), busy_o[i], 0);
            chk($sformatf("u%0d idle data_valid", i), dv_o[i], 0);
            chk($sformatf("u%0d idle sample", i), sample_o[i], 0);
        end
    endtask

    // Follows one result, from the cycle after acceptance (or after DONE) through its DONE cycle.
    task automatic watch(input int i, input int ch, input bit junk, input bit drop_cont);
        int b, t, l, cc, k, v;
        bit conv, dec, ideal;
        logic [31:0] exp_dac;
        b = (i == 0) ? 1 : 3;
        t = S + P * b;
        l = OSR_N * t + 1;
        v = int'(vin[ch]);
        for (int c = 1; c <= l; c++) begin
            @(negedge clk);
            start_i[i] = junk && (c == 1 || c == l);
            if (drop_cont && c == 3) cont_i[i] = 1'b0;
            cc = (c - 1) % t + 1;
            conv = (c < l) && (cc > S);
            exp_dac = 0;
            if (conv) begin
                k = P - 1 - (cc - S - 1) / b;
                exp_dac = 32'(((v >> (k + 1)) << (k + 1)) | (1 << k));
            end
            chk($sformatf("u%0d c%0d sample", i, c), sample_o[i], 32'((c < l) && (cc <= S)));
            chk($sformatf("u%0d c%0d dac_code", i, c), dac_o[i], exp_dac);
            chk($sformatf("u%0d c%0d busy", i, c), busy_o[i], 1);
            chk($sformatf("u%0d c%0d ch_sel", i, c), ch_sel_o[i], 32'(ch));
            chk($sformatf("u%0d c%0d data_valid", i, c), dv_o[i], 32'(c == l));
            if (c == l) begin
                chk($sformatf("u%0d data_out", i), dout_o[i], 32'(v));
                chk($sformatf("u%0d data_ch", i), dch_o[i], 32'(ch));
                $display("[TB] u%0d ch%0d vin=%h data_out=%h data_ch=%0d at cycle %0d",
                         i, ch, vin[ch], dout_o[i], dch_o[i], c);
            end
            // Ideal comparator on decision cycles; the opposite verdict elsewhere in a trial.
            dec = conv && ((cc - S) % b == 0);
            ideal = (v >= int'(dac_o[i]));
            if (dec) cmp_i[i] = ideal;
            else if (conv) cmp_i[i] = !ideal;
            else cmp_i[i] = 1'($urandom_range(0, 1));
        end
        exp_ptr[i] = (ch + 1) % N;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b1;
            start_i[i] = 1'b0;
            cont_i[i] = 1'b0;
            cmp_i[i] = 1'b0;
            exp_ptr[i] = 0;
        end
        for (int j = 0; j < N; j++) vin[j] = 4'h0;

        reset_inst(0);
        reset_inst(1);

        // Single conversion of 0xA on channel 0.
        vin[0] = 4'hA;
        start_conv(0);
        watch(0, 0, 1'b0, 1'b0);
        idle_check(0, 3);

        // Starts during SAMPLE and DONE must be ignored.
        vin[1] = 4'h6;
        start_conv(0);
        watch(0, exp_ptr[0], 1'b1, 1'b0);
        idle_check(0, 3);

        // Continuous mode with wrap-around; cont dropped mid-conversion on the last one.
        reset_inst(0);
        vin[0] = 4'h3; vin[1] = 4'hF; vin[2] = 4'h0;
        cont_i[0] = 1'b1;
        start_conv(0);
        for (int n = 0; n < 6; n++) watch(0, n % N, 1'b0, n == 5);
        idle_check(0, 3);

        // Three-cycle trials with a misleading comparator between decision points.
        vin[0] = 4'h5;
        start_conv(1);
        watch(1, 0, 1'b0, 1'b0);
        idle_check(1, 2);

        // Reset during the second CONVERT cycle of channel 1.
        vin[0] = 4'h9;
        start_conv(0);
        watch(0, exp_ptr[0], 1'b0, 1'b0);
        start_conv(0);
        for (int c = 1; c <= S + 2; c++) begin
            @(negedge clk);
            start_i[0] = 1'b0;
        end
        rst_i[0] = 1'b1;
        @(negedge clk);
        chk_zero(0, "abort");
        rst_i[0] = 1'b0;
        exp_ptr[0] = 0;
        idle_check(0, 3);
        start_conv(0);
        watch(0, 0, 1'b0, 1'b0);
        idle_check(0, 1);

        // Randomized codes and instances.
        for (int r = 0; r < 10; r++) begin
            int i;
            for (int j = 0; j < N; j++) vin[j] = 4'($urandom_range(0, 15));
            if (r == 0) vin[exp_ptr[0]] = 4'hF;
            i = int'($urandom_range(0, 1));
            start_conv(i);
            watch(i, exp_ptr[i], 1'($urandom_range(0, 1)), 1'b0);
            idle_check(i, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
